fifo_fwft_block_reader: RTL and testbench

Synthesizable, parametrised block reader for first-word-fall-through (FWFT) FIFOs. It drains a programmed number of words at a pseudo-random throttled rate and checks each word against an incrementing expected sequence. It also flags per-word timeouts. It sits on the read side of a FIFO under test in hardware test harnesses and replaces behavioural reader tasks so the same stimulus runs in simulation and on FPGA.

---
 rtl/fifo_bench_pkg.sv | 20 ++
 rtl/fifo_rate_lfsr.sv | 37 +++
 rtl/fifo_fwft_block_reader.sv | 140 ++++++++++++++
 tb/tb_fifo_fwft_block_reader.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_bench_pkg.sv
// Shared types and constants for the FWFT FIFO block reader and its throttle LFSR.
package fifo_bench_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [7:0]  RATE_NEVER   = 8'd0;
  localparam logic [7:0]  RATE_ALWAYS  = 8'd255;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/fifo_rate_lfsr.sv
// Pseudo-random read throttle: a 16-bit Galois LFSR whose low byte is compared
// against the rate to produce a registered read permit.
module fifo_rate_lfsr
  import fifo_bench_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [15:0] i_seed,
  input  logic        i_step,
  input  logic [7:0]  i_rate,
  output logic        o_permit
);

  logic [15:0] r_lfsr;
  logic        r_permit;
  logic        w_permit_next;

  // The full-rate case is special-cased because lfsr[7:0] can equal 255.
  assign w_permit_next = (i_rate == RATE_ALWAYS) || (r_lfsr[7:0] < i_rate);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr   <= DEFAULT_SEED;
      r_permit <= 1'b0;
    end else if (i_load) begin
      r_lfsr   <= (i_seed == 16'h0000) ? DEFAULT_SEED : i_seed;
      r_permit <= 1'b0;
    end else if (i_step) begin
      r_lfsr   <= lfsr_step(r_lfsr);
      r_permit <= w_permit_next;
    end
  end

  assign o_permit = r_permit;

endmodule

// File: rtl/fifo_fwft_block_reader.sv
// Drains a programmed block of words from an FWFT FIFO at a throttled rate,
// checking each against an incrementing expected value and flagging stalls.
module fifo_fwft_block_reader
  import fifo_bench_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEN_W = 16,
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [LEN_W-1:0] length_i,
  input  logic [7:0]       rate_i,
  input  logic [15:0]      seed_i,
  input  logic [TMO_W-1:0] timeout_i,
  input  logic [WIDTH-1:0] exp_init_i,
  input  logic [WIDTH-1:0] din,
  input  logic             empty,
  output logic             rden,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic [LEN_W-1:0] err_count,
  output logic [LEN_W-1:0] word_count
);

  state_t           r_state;
  state_t           w_state_next;
  logic [LEN_W-1:0] r_length;
  logic [LEN_W-1:0] r_word_count;
  logic [LEN_W-1:0] r_err_count;
  logic [TMO_W-1:0] r_timeout;
  logic [TMO_W-1:0] r_tmo;
  logic [WIDTH-1:0] r_exp;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_err_timeout;
  logic             w_permit;
  logic             w_in_read;
  logic             w_start;
  logic             w_accept;
  logic             w_last;
  logic             w_tmo_hit;

  assign w_in_read = (r_state == ST_READ);
  assign w_start   = start_i && (r_state == ST_IDLE);
  assign w_accept  = w_in_read && w_permit && !empty;
  assign w_last    = w_accept && (r_word_count == r_length - LEN_W'(1));
  // Fires in the cycle the wait counter would reach the limit; an accept wins.
  assign w_tmo_hit = w_in_read && !w_accept && (r_timeout != '0) &&
                     (r_tmo == r_timeout - TMO_W'(1));

  fifo_rate_lfsr u_rate (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_start),
    .i_seed   (seed_i),
    .i_step   (w_in_read),
    .i_rate   (rate_i),
    .o_permit (w_permit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_next = (length_i == '0) ? ST_FINISH : ST_READ;
        end
      end
      ST_READ: begin
        if (w_last || w_tmo_hit) begin
          w_state_next = ST_FINISH;
        end
      end
      ST_FINISH: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_length      <= '0;
      r_timeout     <= '0;
      r_exp         <= '0;
      r_tmo         <= '0;
      r_dout        <= '0;
      r_dout_valid  <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_count   <= '0;
      r_word_count  <= '0;
    end else begin
      r_dout_valid <= 1'b0;
      if (w_start) begin
        r_length      <= length_i;
        r_timeout     <= timeout_i;
        r_exp         <= exp_init_i;
        r_tmo         <= '0;
        r_err_timeout <= 1'b0;
        r_err_count   <= '0;
        r_word_count  <= '0;
      end else if (w_accept) begin
        r_dout       <= din;
        r_dout_valid <= 1'b1;
        r_word_count <= r_word_count + LEN_W'(1);
        r_exp        <= r_exp + WIDTH'(1);
        r_tmo        <= '0;
        if ((din != r_exp) && (r_err_count != '1)) begin
          r_err_count <= r_err_count + LEN_W'(1);
        end
      end else if (w_in_read && (r_timeout != '0)) begin
        r_tmo <= r_tmo + TMO_W'(1);
        if (w_tmo_hit) begin
          r_err_timeout <= 1'b1;
        end
      end
    end
  end

  assign rden        = w_accept;
  assign dout        = r_dout;
  assign dout_valid  = r_dout_valid;
  assign busy        = w_in_read;
  assign done        = (r_state == ST_FINISH);
  assign err_timeout = r_err_timeout;
  assign err_count   = r_err_count;
  assign word_count  = r_word_count;

endmodule

// File: tb/tb_fifo_fwft_block_reader.sv
// Bench for fifo_fwft_block_reader: a queue-backed FWFT FIFO feeds the reader,
// and each block's results are compared with values derived from the pushed data.
module tb_fifo_fwft_block_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [15:0] length_i;
  logic [7:0]  rate_i;
  logic [15:0] seed_i;
  logic [15:0] timeout_i;
  logic [31:0] exp_init_i;
  logic [31:0] din;
  logic        empty;
  logic        rden;
  logic [31:0] dout;
  logic        dout_valid;
  logic        busy;
  logic        done;
  logic        err_timeout;
  logic [15:0] err_count;
  logic [15:0] word_count;

  int total = 0;
  int bad   = 0;

  fifo_fwft_block_reader dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .length_i    (length_i),
    .rate_i      (rate_i),
    .seed_i      (seed_i),
    .timeout_i   (timeout_i),
    .exp_init_i  (exp_init_i),
    .din         (din),
    .empty       (empty),
    .rden        (rden),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .err_count   (err_count),
    .word_count  (word_count)
  );

  always #5 clk = ~clk;

  // FWFT FIFO model: head word always visible, popped on rden.
  logic [31:0] mem [4096];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        stall = 1'b0;
  logic [31:0] exp_q [$];

  assign din   = mem[rd_ptr[11:0]];
  assign empty = (rd_ptr == wr_ptr) || stall;

  always @(posedge clk) begin
    if (rden) rd_ptr <= rd_ptr + 1;
  end

  task automatic push_word(input logic [31:0] v);
    mem[wr_ptr[11:0]] = v;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(v);
  endtask

  // Observations of the most recent block.
  logic [31:0] obs_dout [$];
  int   o_rden_cnt, o_bad_rden, o_busy_cnt, o_ne_read, o_first_rden, o_last_rden;
  int   o_max_run, o_done_cnt, o_done_c;
  logic o_done_seen, o_busy_at_done, o_tmo_at_done, o_tmo_after;
  logic [15:0] o_wc, o_ec;

  task automatic run_block(input logic [15:0] len, input logic [7:0] rate,
                           input logic [15:0] seed, input logic [15:0] tmo,
                           input logic [31:0] exp0, input int stall_pct,
                           input int budget, input int restart_c);
    int run;
    obs_dout.delete();
    o_rden_cnt = 0; o_bad_rden = 0; o_busy_cnt = 0; o_ne_read = 0;
    o_first_rden = -1; o_last_rden = -1; o_max_run = 0; o_done_cnt = 0;
    o_done_c = -1; o_done_seen = 1'b0; o_busy_at_done = 1'b0;
    o_tmo_at_done = 1'b0; o_tmo_after = 1'b0; o_wc = '0; o_ec = '0;
    run = 0;
    @(negedge clk);
    length_i = len; rate_i = rate; seed_i = seed; timeout_i = tmo;
    exp_init_i = exp0; start_i = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start_i = (c == restart_c);
      if (c == restart_c) begin
        length_i = 16'd3;
        exp_init_i = 32'h5555_0000;
      end
      stall = ($urandom_range(99) < stall_pct);
      #1;
      if (rden && empty) o_bad_rden++;
      if (busy) o_busy_cnt++;
      if (busy && !empty) o_ne_read++;
      if (rden) begin
        o_rden_cnt++;
        o_last_rden = c;
        if (o_first_rden < 0) o_first_rden = c;
        run++;
        if (run > o_max_run) o_max_run = run;
      end else begin
        run = 0;
      end
      if (dout_valid) obs_dout.push_back(dout);
      if (done) begin
        o_done_cnt++;
        o_done_c = c;
        o_done_seen = 1'b1;
        o_busy_at_done = busy;
        o_tmo_at_done = err_timeout;
        o_wc = word_count;
        o_ec = err_count;
        break;
      end
    end
    start_i = 1'b0;
    stall = 1'b0;
    if (o_done_seen) begin
      @(negedge clk);
      #1;
      if (done) o_done_cnt++;
      o_tmo_after = err_timeout;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start_i = 1'b0; length_i = '0; rate_i = '0; seed_i = '0;
    timeout_i = '0; exp_init_i = '0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (rden !== 1'b0) begin bad++; $display("FAIL reset_rden got=%b want=0", rden); end
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL reset_dout got=%h want=0", dout); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_dout_valid got=%b want=0", dout_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL reset_err_timeout got=%b want=0", err_timeout); end
    total++; if (err_count !== 16'h0) begin bad++; $display("FAIL reset_err_count got=%0d want=0", err_count); end
    total++; if (word_count !== 16'h0) begin bad++; $display("FAIL reset_word_count got=%0d want=0", word_count); end
    @(negedge clk);
    rst = 1'b0;
    $display("reset: checked all outputs");
  endtask

  task automatic test_full_rate;
    exp_q.delete();
    for (int i = 0; i < 8; i++) push_word(32'(i));
    run_block(16'd8, 8'd255, 16'h0042, 16'd0, 32'd0, 0, 100, -1);
    total++; if (o_rden_cnt != 8) begin bad++; $display("FAIL full_rden_cnt got=%0d want=8", o_rden_cnt); end
    total++; if (o_max_run != 8) begin bad++; $display("FAIL full_consecutive got=%0d want=8", o_max_run); end
    total++; if (o_first_rden != 2) begin bad++; $display("FAIL full_first_rden got=%0d want=2", o_first_rden); end
    total++; if (o_done_c != o_last_rden + 1) begin bad++; $display("FAIL full_done_lat got=%0d want=%0d", o_done_c, o_last_rden + 1); end
    total++; if (o_done_cnt != 1) begin bad++; $display("FAIL full_done_pulses got=%0d want=1", o_done_cnt); end
    total++; if (o_busy_at_done !== 1'b0) begin bad++; $display("FAIL full_busy_in_finish got=%b want=0", o_busy_at_done); end
    total++; if (o_busy_cnt != 9) begin bad++; $display("FAIL full_busy_cycles got=%0d want=9", o_busy_cnt); end
    total++; if (o_wc !== 16'd8) begin bad++; $display("FAIL full_word_count got=%0d want=8", o_wc); end
    total++; if (o_ec !== 16'd0) begin bad++; $display("FAIL full_err_count got=%0d want=0", o_ec); end
    total++; if (obs_dout.size() != 8) begin bad++; $display("FAIL full_dout_count got=%0d want=8", obs_dout.size()); end
    for (int i = 0; i < obs_dout.size() && i < 8; i++) begin
      total++; if (obs_dout[i] !== exp_q[i]) begin bad++; $display("FAIL full_dout[%0d] got=%h want=%h", i, obs_dout[i], exp_q[i]); end
    end
    $display("full_rate: words=%0d errs=%0d done_at=%0d", o_wc, o_ec, o_done_c);
  endtask

  task automatic test_mismatch;
    exp_q.delete();
    for (int i = 0; i < 8; i++) push_word((i == 3) ? 32'hDEAD : 32'(i));
    run_block(16'd8, 8'd255, 16'h0000, 16'd0, 32'd0, 0, 100, -1);
    total++; if (o_ec !== 16'd1) begin bad++; $display("FAIL mism_err_count got=%0d want=1", o_ec); end
    total++; if (o_wc !== 16'd8) begin bad++; $display("FAIL mism_word_count got=%0d want=8", o_wc); end
    total++; if (obs_dout.size() != 8) begin bad++; $display("FAIL mism_dout_count got=%0d want=8", obs_dout.size()); end
    for (int i = 0; i < obs_dout.size() && i < 8; i++) begin
      total++; if (obs_dout[i] !== exp_q[i]) begin bad++; $display("FAIL mism_dout[%0d] got=%h want=%h", i, obs_dout[i], exp_q[i]); end
    end
    $display("mismatch: words=%0d errs=%0d", o_wc, o_ec);
  endtask

  task automatic test_timeout;
    exp_q.delete();
    run_block(16'd4, 8'd0, 16'h0001, 16'd20, 32'd0, 0, 100, -1);
    total++; if (!o_done_seen) begin bad++; $display("FAIL tmo_done got=none want=pulse"); end
    total++; if (o_rden_cnt != 0) begin bad++; $display("FAIL tmo_rden got=%0d want=0", o_rden_cnt); end
    total++; if (o_busy_cnt != 20) begin bad++; $display("FAIL tmo_read_cycles got=%0d want=20", o_busy_cnt); end
    total++; if (o_tmo_at_done !== 1'b1) begin bad++; $display("FAIL tmo_flag got=%b want=1", o_tmo_at_done); end
    total++; if (o_tmo_after !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%b want=1", o_tmo_after); end
    total++; if (o_wc !== 16'd0) begin bad++; $display("FAIL tmo_word_count got=%0d want=0", o_wc); end
    total++; if (o_done_cnt != 1) begin bad++; $display("FAIL tmo_done_pulses got=%0d want=1", o_done_cnt); end
    $display("timeout: read_cycles=%0d flag=%b", o_busy_cnt, o_tmo_at_done);
  endtask

  task automatic test_zero_len;
    exp_q.delete();
    run_block(16'd0, 8'd255, 16'h0001, 16'd5, 32'd0, 0, 10, -1);
    total++; if (!o_done_seen || o_done_c > 2) begin bad++; $display("FAIL zero_done_at got=%0d want<=2", o_done_c); end
    total++; if (o_busy_cnt != 0) begin bad++; $display("FAIL zero_busy got=%0d want=0", o_busy_cnt); end
    total++; if (o_rden_cnt != 0) begin bad++; $display("FAIL zero_rden got=%0d want=0", o_rden_cnt); end
    total++; if (o_tmo_at_done !== 1'b0) begin bad++; $display("FAIL zero_tmo_cleared got=%b want=0", o_tmo_at_done); end
    $display("zero_len: done_at=%0d", o_done_c);
  endtask

  task automatic test_start_while_busy;
    exp_q.delete();
    for (int i = 0; i < 10; i++) push_word(32'h2000 + 32'(i));
    run_block(16'd10, 8'd255, 16'h0007, 16'd0, 32'h2000, 0, 100, 4);
    total++; if (o_wc !== 16'd10) begin bad++; $display("FAIL restart_word_count got=%0d want=10", o_wc); end
    total++; if (o_ec !== 16'd0) begin bad++; $display("FAIL restart_err_count got=%0d want=0", o_ec); end
    total++; if (o_done_cnt != 1) begin bad++; $display("FAIL restart_done_pulses got=%0d want=1", o_done_cnt); end
    $display("start_while_busy: words=%0d errs=%0d", o_wc, o_ec);
  endtask

  task automatic test_throttled;
    logic [31:0] exp0;
    int pct;
    exp_q.delete();
    exp0 = $urandom;
    for (int i = 0; i < 100; i++) push_word(exp0 + 32'(i));
    run_block(16'd100, 8'd64, 16'h1234, 16'd0, exp0, 50, 5000, -1);
    pct = (o_ne_read > 0) ? (o_rden_cnt * 100) / o_ne_read : 0;
    total++; if (o_wc !== 16'd100) begin bad++; $display("FAIL thr_word_count got=%0d want=100", o_wc); end
    total++; if (o_ec !== 16'd0) begin bad++; $display("FAIL thr_err_count got=%0d want=0", o_ec); end
    total++; if (o_bad_rden != 0) begin bad++; $display("FAIL thr_rden_while_empty got=%0d want=0", o_bad_rden); end
    total++; if (pct < 15 || pct > 35) begin bad++; $display("FAIL thr_duty got=%0d%% want=15..35%%", pct); end
    total++; if (obs_dout.size() != 100) begin bad++; $display("FAIL thr_dout_count got=%0d want=100", obs_dout.size()); end
    for (int i = 0; i < obs_dout.size() && i < 100; i++) begin
      total++; if (obs_dout[i] !== exp_q[i]) begin bad++; $display("FAIL thr_dout[%0d] got=%h want=%h", i, obs_dout[i], exp_q[i]); end
    end
    $display("throttled: words=%0d duty=%0d%% cycles=%0d", o_wc, pct, o_done_c);
  endtask

  task automatic test_reset_mid;
    int consumed;
    int left;
    logic [31:0] head;
    exp_q.delete();
    for (int i = 0; i < 20; i++) push_word(32'h100 + 32'(i));
    run_block(16'd20, 8'd255, 16'h0003, 16'd0, 32'h100, 0, 6, -1);
    consumed = o_rden_cnt;
    @(negedge clk);
    rst = 1'b1;
    #1;
    if (rden) consumed++;
    @(negedge clk);
    #1;
    total++; if (o_done_seen) begin bad++; $display("FAIL rmid_early_done got=1 want=0"); end
    total++; if ({rden, dout_valid, busy, done, err_timeout} !== 5'b0) begin bad++; $display("FAIL rmid_flags got=%b want=00000", {rden, dout_valid, busy, done, err_timeout}); end
    total++; if ({dout, err_count, word_count} !== 64'h0) begin bad++; $display("FAIL rmid_values got=%h/%0d/%0d want=0/0/0", dout, err_count, word_count); end
    rst = 1'b0;
    o_done_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (done) o_done_cnt++;
    end
    total++; if (o_done_cnt != 0) begin bad++; $display("FAIL rmid_done_after_reset got=%0d want=0", o_done_cnt); end
    left = 20 - consumed;
    head = 32'h100 + 32'(consumed);
    run_block(16'(left), 8'd255, 16'h0009, 16'd0, head, 0, 100, -1);
    total++; if (o_wc !== 16'(left)) begin bad++; $display("FAIL rmid_word_count got=%0d want=%0d", o_wc, left); end
    total++; if (o_ec !== 16'd0) begin bad++; $display("FAIL rmid_err_count got=%0d want=0", o_ec); end
    total++; if (obs_dout.size() != left) begin bad++; $display("FAIL rmid_dout_count got=%0d want=%0d", obs_dout.size(), left); end
    for (int i = 0; i < obs_dout.size() && i < left; i++) begin
      total++; if (obs_dout[i] !== exp_q[consumed + i]) begin bad++; $display("FAIL rmid_dout[%0d] got=%h want=%h", i, obs_dout[i], exp_q[consumed + i]); end
    end
    $display("reset_mid: consumed=%0d resumed=%0d", consumed, o_wc);
  endtask

  task automatic test_random_blocks;
    for (int b = 0; b < 6; b++) begin
      int len;
      int nerr;
      logic [7:0]  rate;
      logic [31:0] exp0;
      logic [31:0] good;
      logic [31:0] v;
      exp_q.delete();
      len  = $urandom_range(20, 1);
      rate = 8'($urandom_range(255, 16));
      exp0 = (b % 2 == 0) ? $urandom : 32'hFFFF_FFFC;
      nerr = 0;
      for (int i = 0; i < len; i++) begin
        good = exp0 + 32'(i);
        v = ($urandom_range(99) < 20) ? (good ^ (32'h1 << $urandom_range(31))) : good;
        if (v != good) nerr++;
        push_word(v);
      end
      run_block(16'(len), rate, 16'($urandom), 16'd0, exp0, 30, 3000, -1);
      total++; if (!o_done_seen) begin bad++; $display("FAIL rnd%0d_done got=none want=pulse", b); end
      total++; if (o_wc !== 16'(len)) begin bad++; $display("FAIL rnd%0d_word_count got=%0d want=%0d", b, o_wc, len); end
      total++; if (o_ec !== 16'(nerr)) begin bad++; $display("FAIL rnd%0d_err_count got=%0d want=%0d", b, o_ec, nerr); end
      total++; if (o_bad_rden != 0) begin bad++; $display("FAIL rnd%0d_rden_while_empty got=%0d want=0", b, o_bad_rden); end
      total++; if (obs_dout.size() != len) begin bad++; $display("FAIL rnd%0d_dout_count got=%0d want=%0d", b, obs_dout.size(), len); end
      for (int i = 0; i < obs_dout.size() && i < len; i++) begin
        total++; if (obs_dout[i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_dout[%0d] got=%h want=%h", b, i, obs_dout[i], exp_q[i]); end
      end
      $display("random block %0d: len=%0d rate=%0d exp0=%h errs=%0d", b, len, rate, exp0, o_ec);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_full_rate();
    test_mismatch();
    test_timeout();
    test_zero_len();
    test_start_while_busy();
    test_throttled();
    test_reset_mid();
    test_random_blocks();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
